// File: rtl/nn_pkg.sv
// Shared definitions for the neuron MAC datapath.
//   NN_DW     : default activation/weight/bias width
//   NN_ACC_W  : default accumulator/result width
//   state_t   : sequencer states
//   sext_acc  : sign-extends the low w bits of a value to the accumulator width
package nn_pkg;

  localparam int NN_DW    = 8;
  localparam int NN_ACC_W = 21;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Value arrives zero-padded to 2*NN_DW bits; bit w-1 is its sign.
  // The pair of shifts moves that sign bit to the MSB and back arithmetically.
  function automatic logic [NN_ACC_W-1:0] sext_acc(input logic [2*NN_DW-1:0] v,
                                                   input int w);
    logic [NN_ACC_W-1:0] r;
    r = NN_ACC_W'(v) << (NN_ACC_W - w);
    r = $signed(r) >>> (NN_ACC_W - w);
    return r;
  endfunction

endpackage

// File: rtl/mul_s8.sv
// Combinational signed DW x DW -> 2*DW multiplier.
//   a, b : signed operands
//   p    : full-width signed product
module mul_s8 #(
  parameter int DW = 8
) (
  input  logic signed [DW-1:0]   a,
  input  logic signed [DW-1:0]   b,
  output logic signed [2*DW-1:0] p
);

  // Operands widened first so the multiply is done at full product width.
  logic signed [2*DW-1:0] a_w;
  logic signed [2*DW-1:0] b_w;

  assign a_w = {{DW{a[DW-1]}}, a};
  assign b_w = {{DW{b[DW-1]}}, b};
  assign p   = a_w * b_w;

endmodule

// File: rtl/neuron_mac_seq.sv
// Single-neuron multiply-accumulate sequencer feeding the result register.
//   clk, rst          : clock, async active-high reset
//   start, bias,
//   relu_en           : begin evaluation (bias/relu_en captured with start)
//   clr               : synchronous abort to IDLE
//   x_in, w_in,
//   in_valid/in_ready : pair handshake, one pair per cycle
//   busy              : evaluation in progress (ACC or DONE)
//   sum_out           : result, held until next completion
//   out_valid         : one-cycle strobe when sum_out updates
//
// state | meaning
// IDLE  | waiting for start
// ACC   | accepting pairs, accumulating products
// DONE  | all pairs taken, result registered on exit
module neuron_mac_seq
  import nn_pkg::*;
#(
  parameter int DW    = NN_DW,
  parameter int ACC_W = NN_ACC_W,
  parameter int N_IN  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [DW-1:0]    bias,
  input  logic                    relu_en,
  input  logic                    clr,
  input  logic signed [DW-1:0]    x_in,
  input  logic signed [DW-1:0]    w_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    busy,
  output logic [ACC_W-1:0]        sum_out,
  output logic                    out_valid
);

  localparam int CW = $clog2(N_IN + 1);

  state_t                 state, state_nxt;
  logic [ACC_W-1:0]       acc;
  logic [CW-1:0]          cnt;
  logic                   relu_q;
  logic signed [2*DW-1:0] prod;
  logic [ACC_W-1:0]       prod_ext;
  logic [ACC_W-1:0]       bias_ext;
  logic                   go;
  logic                   last;

  mul_s8 #(.DW(DW)) u_mul (
    .a (x_in),
    .b (w_in),
    .p (prod)
  );

  assign prod_ext = sext_acc(prod, 2*DW);
  assign bias_ext = sext_acc({{DW{1'b0}}, bias}, DW);

  // out_valid is high in the IDLE cycle right after DONE; a start seen then
  // is dropped so a back-to-back start cannot overlap the result strobe.
  assign go   = (state == IDLE) && start && !out_valid;
  assign last = (state == ACC) && in_valid && (cnt == CW'(N_IN - 1));

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: if (go) state_nxt = ACC;
      ACC: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (clr) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      relu_q    <= 1'b0;
      sum_out   <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= 1'b0;
      if (clr) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        case (state)
          IDLE: if (go) begin
            acc    <= bias_ext;
            cnt    <= '0;
            relu_q <= relu_en;
          end
          ACC: if (in_valid) begin
            acc <= acc + prod_ext;
            cnt <= cnt + CW'(1);
          end
          DONE: begin
            sum_out   <= (relu_q && acc[ACC_W-1]) ? '0 : acc;
            out_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed bench for neuron_mac_seq: a 4-input instance for most scenarios and
// a 16-input instance for the maximum-magnitude case.
module tb_neuron_mac_seq;

  logic              clk = 1'b0;
  logic              rst;
  logic              start4, start16;
  logic signed [7:0] bias;
  logic              relu_en;
  logic              clr;
  logic signed [7:0] x_in, w_in;
  logic              in_valid;

  logic              in_ready4, busy4, out_valid4;
  logic [20:0]       sum_out4;
  logic              in_ready16, busy16, out_valid16;
  logic [20:0]       sum_out16;

  int total  = 0;
  int passes = 0;

  always #5 clk = ~clk;

  neuron_mac_seq #(.DW(8), .ACC_W(21), .N_IN(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .bias(bias), .relu_en(relu_en),
    .clr(clr), .x_in(x_in), .w_in(w_in), .in_valid(in_valid),
    .in_ready(in_ready4), .busy(busy4), .sum_out(sum_out4),
    .out_valid(out_valid4)
  );

  neuron_mac_seq #(.DW(8), .ACC_W(21), .N_IN(16)) u16 (
    .clk(clk), .rst(rst), .start(start16), .bias(bias), .relu_en(relu_en),
    .clr(1'b0), .x_in(x_in), .w_in(w_in), .in_valid(in_valid),
    .in_ready(in_ready16), .busy(busy16), .sum_out(sum_out16),
    .out_valid(out_valid16)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic signed [7:0] b, input logic r);
    bias    = b;
    relu_en = r;
    start4  = 1'b1;
    tick();
    start4  = 1'b0;
  endtask

  task automatic feed(input logic signed [7:0] x, input logic signed [7:0] w);
    x_in     = x;
    w_in     = w;
    in_valid = 1'b1;
    tick();
  endtask

  // Called right after the edge that accepted the last pair.
  task automatic finish4(input string tag, input logic [20:0] exp);
    in_valid = 1'b0;
    chk({tag, "_done_busy"}, 32'(busy4), 32'd1);
    chk({tag, "_done_ov"}, 32'(out_valid4), 32'd0);
    tick();
    chk({tag, "_ov"}, 32'(out_valid4), 32'd1);
    chk({tag, "_sum"}, 32'(sum_out4), 32'(exp));
    tick();
    chk({tag, "_ov_drop"}, 32'(out_valid4), 32'd0);
    chk({tag, "_hold"}, 32'(sum_out4), 32'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start4 = 1'b0; start16 = 1'b0; bias = '0; relu_en = 1'b0;
    clr = 1'b0; x_in = '0; w_in = '0; in_valid = 1'b0;
    #3;
    chk("rst_sum", 32'(sum_out4), 32'd0);
    chk("rst_ov", 32'(out_valid4), 32'd0);
    chk("rst_ready", 32'(in_ready4), 32'd0);
    chk("rst_busy", 32'(busy4), 32'd0);
    #4 rst = 1'b0;
    tick();
    chk("idle_ready", 32'(in_ready4), 32'd0);

    // Basic sum: 1+2+3+4
    start_run(8'sd0, 1'b0);
    chk("b_ready", 32'(in_ready4), 32'd1);
    chk("b_busy", 32'(busy4), 32'd1);
    feed(8'sd1, 8'sd1);
    feed(8'sd2, 8'sd1);
    feed(8'sd3, 8'sd1);
    feed(8'sd4, 8'sd1);
    chk("b_ready_done", 32'(in_ready4), 32'd0);
    finish4("basic", 21'd10);
    chk("b_busy_after", 32'(busy4), 32'd0);

    // Maximum magnitude on 16-input instance
    bias = 8'sd127; relu_en = 1'b0; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    for (int i = 0; i < 16; i++) feed(-8'sd128, -8'sd128);
    in_valid = 1'b0;
    chk("max_ov_early", 32'(out_valid16), 32'd0);
    tick();
    chk("max_ov", 32'(out_valid16), 32'd1);
    chk("max_sum", 32'(sum_out16), 32'h4007F);
    tick();

    // Negative result, ReLU off; relu_en toggled on mid-run
    start_run(-8'sd5, 1'b0);
    relu_en = 1'b1;
    for (int i = 0; i < 4; i++) feed(8'sd0, 8'sd0);
    finish4("neg", 21'h1FFFFB);

    // Same with ReLU on; relu_en toggled off mid-run
    start_run(-8'sd5, 1'b1);
    relu_en = 1'b0;
    for (int i = 0; i < 4; i++) feed(8'sd0, 8'sd0);
    finish4("relu", 21'd0);

    // Handshake gaps: valid 1,0,0,1,0,1,1; junk on idle cycles
    start_run(8'sd0, 1'b0);
    feed(8'sd2, 8'sd3);
    in_valid = 1'b0; x_in = 8'sd100; w_in = 8'sd100;
    tick();
    chk("gap_ready1", 32'(in_ready4), 32'd1);
    tick();
    feed(-8'sd1, 8'sd5);
    in_valid = 1'b0; x_in = 8'sd100; w_in = 8'sd100;
    tick();
    chk("gap_ready2", 32'(in_ready4), 32'd1);
    feed(8'sd4, 8'sd4);
    chk("gap_ready3", 32'(in_ready4), 32'd1);
    feed(8'sd1, -8'sd7);
    finish4("gap", 21'd10);

    // start held through ACC/DONE with a different bias: must not restart
    start_run(8'sd0, 1'b0);
    start4 = 1'b1; bias = 8'sd50;
    feed(8'sd1, 8'sd1);
    feed(8'sd2, 8'sd1);
    feed(8'sd3, 8'sd1);
    feed(8'sd4, 8'sd1);
    in_valid = 1'b0;
    chk("ign_done_busy", 32'(busy4), 32'd1);
    tick();
    chk("ign_ov", 32'(out_valid4), 32'd1);
    chk("ign_sum", 32'(sum_out4), 32'd10);
    bias = 8'sd0;
    tick();
    chk("ign_start_on_ov", 32'(in_ready4), 32'd0);
    tick();
    start4 = 1'b0;
    chk("start_after_ov", 32'(in_ready4), 32'd1);

    // clr after two accepted pairs
    feed(8'sd3, 8'sd1);
    feed(8'sd4, 8'sd1);
    in_valid = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_ready", 32'(in_ready4), 32'd0);
    chk("clr_busy", 32'(busy4), 32'd0);
    chk("clr_ov", 32'(out_valid4), 32'd0);
    chk("clr_sum", 32'(sum_out4), 32'd10);
    tick();
    chk("clr_ov2", 32'(out_valid4), 32'd0);

    // Async reset mid-ACC
    start_run(8'sd0, 1'b0);
    feed(8'sd5, 8'sd5);
    feed(8'sd5, 8'sd5);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("arst_sum", 32'(sum_out4), 32'd0);
    chk("arst_ov", 32'(out_valid4), 32'd0);
    chk("arst_ready", 32'(in_ready4), 32'd0);
    chk("arst_busy", 32'(busy4), 32'd0);
    #1 rst = 1'b0;
    tick();
    start_run(8'sd3, 1'b0);
    feed(8'sd1, 8'sd2);
    feed(8'sd2, 8'sd2);
    feed(8'sd3, 8'sd2);
    feed(8'sd4, 8'sd2);
    finish4("post_rst", 21'd23);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
